step_ctrl: RTL and testbench
============================

STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter RATE_DIV, default 12500000, SHALL set the CLK cycles between auto-steps in RUN and BURST (4 Hz at 50 MHz); legal range >= 2.
REQ-002 Parameter BURST_LEN, default 16, SHALL set the number of steps issued per burst; legal range 1..65535.
REQ-003 CLK  input  1  SHALL be the single system clock (MAX10_CLK1_50 domain).
REQ-004 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 STEP  input  1  SHALL be a one-cycle single-step request pulse (debounced key).
REQ-006 BURST  input  1  SHALL be a one-cycle burst request pulse.
REQ-007 RUN  input  1  SHALL be a level; high requests free-running auto-step.
REQ-008 HALT  input  1  SHALL be a level halt request; stops all stepping.
REQ-009 CPU_CE  output  1  SHALL be a one-cycle clock-enable pulse that advances the processor by one instruction.
REQ-010 BUSY  output  1  SHALL be high in RUN or BURST.
REQ-011 STEP_CNT  output  16  SHALL count CPU_CE pulses issued since reset.
REQ-012 STATE  output  2  SHALL encode IDLE=0, RUN=1, BURST=2, HALTED=3.

Function
REQ-013 All outputs SHALL be registered; CPU_CE SHALL assert the cycle after the qualifying event and never for two consecutive cycles.
REQ-014 IDLE: STEP pulse SHALL give one CPU_CE; RUN high SHALL go to RUN; BURST pulse SHALL go to BURST, loading remaining count BURST_LEN.
REQ-015 RUN: a rate counter SHALL count 0..RATE_DIV-1, clear on state entry, and issue CPU_CE on each wrap to 0 (first CPU_CE RATE_DIV cycles after entry); RUN low SHALL return to IDLE without a further CPU_CE.
REQ-016 BURST: CPU_CE SHALL be issued at the same rate; remaining count SHALL decrement per CPU_CE; return to IDLE in the cycle the count reaches 0.
REQ-017 STEP and BURST pulses SHALL be ignored while in RUN or BURST; RUN rising while in BURST SHALL be ignored until BURST completes.
REQ-018 HALT high in any state SHALL go to HALTED next cycle, suppress any CPU_CE due that cycle, and clear rate counter and remaining count.
REQ-019 HALTED SHALL issue no CPU_CE and SHALL exit to IDLE only when HALT and RUN are both low.
REQ-020 Simultaneous events in IDLE SHALL resolve by priority HALT > RUN > BURST > STEP; lower-priority pulses SHALL be discarded.
REQ-021 STEP_CNT SHALL increment with each CPU_CE and wrap 0xFFFF -> 0x0000.

Reset
REQ-022 RST high SHALL on the next CLK edge force STATE=IDLE, CPU_CE=0, BUSY=0, STEP_CNT=0, rate counter=0, remaining count=0, including mid-burst or mid-run.
REQ-023 Inputs SHALL be ignored in any cycle RST is high; no CPU_CE SHALL appear in the cycle after reset deasserts unless STEP was high in that first non-reset cycle.

Configuration
REQ-024 Macro STEP_CTRL_BREAKPOINT_EN defined SHALL add inputs PC[31:0] and BP_ADDR[31:0] and BP_ARM[1]; when BP_ARM=1 and PC==BP_ADDR at a RUN/BURST rate wrap, no CPU_CE SHALL issue and the block SHALL enter HALTED (exit per REQ-019, BP_ARM low also required).
REQ-025 Macro undefined SHALL omit those ports and breakpoint logic; behaviour otherwise identical.

Verification (RATE_DIV=4, BURST_LEN=3)
REQ-026 Reset, STEP pulse at cycle 10 -> CPU_CE high at cycle 11 only, STEP_CNT=1, STATE=0.
REQ-027 RUN high at cycle 0 for 20 cycles -> STATE=1, BUSY=1, CPU_CE at cycles 5,9,13,17; STEP_CNT=4; after RUN low STATE=0, no further CPU_CE.
REQ-028 BURST pulse -> exactly 3 CPU_CE 4 cycles apart, STATE returns 0 with final pulse, STEP pulses during burst ignored, STEP_CNT=3.
REQ-029 HALT high in cycle a CPU_CE is due during RUN -> no CPU_CE, STATE=3; RUN/HALT low -> STATE=0; STEP preset STEP_CNT=0xFFFF then STEP -> STEP_CNT=0x0000.
REQ-030 RST asserted mid-burst after 1 step -> all outputs zero next edge, no residual CPU_CE.
REQ-031 With STEP_CTRL_BREAKPOINT_EN, BP_ARM=1, BP_ADDR=0x00000008, PC advanced 0,4,8 by bench per CPU_CE in RUN -> two CPU_CE, then STATE=3, no third pulse.

Source files
------------

// File: rtl/step_ctrl.sv
// step_ctrl: single-step / free-run / burst clock-enable sequencer for a CPU.
// Optional breakpoint halt is compiled in with `define STEP_CTRL_BREAKPOINT_EN.
//
// Parameters:
//   RATE_DIV  - CLK cycles between auto-steps in RUN and BURST (>= 2)
//   BURST_LEN - steps issued per burst (1..65535)
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-high reset
//   STEP     in   one-cycle single-step request
//   BURST    in   one-cycle burst request
//   RUN      in   level, free-running auto-step request
//   HALT     in   level, stops all stepping
//   CPU_CE   out  one-cycle clock-enable pulse, one instruction each
//   BUSY     out  high while in RUN or BURST
//   STEP_CNT out  CPU_CE pulses since reset (wraps)
//   STATE    out  IDLE=0 RUN=1 BURST=2 HALTED=3
//   PC       in   (breakpoint build) current program counter
//   BP_ADDR  in   (breakpoint build) breakpoint address
//   BP_ARM   in   (breakpoint build) breakpoint enable

module step_ctrl #(
  parameter int RATE_DIV  = 12500000,
  parameter int BURST_LEN = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STEP,
  input  logic        BURST,
  input  logic        RUN,
  input  logic        HALT,
  output logic        CPU_CE,
  output logic        BUSY,
  output logic [15:0] STEP_CNT,
  output logic [1:0]  STATE
`ifdef STEP_CTRL_BREAKPOINT_EN
  ,
  input  logic [31:0] PC,
  input  logic [31:0] BP_ADDR,
  input  logic        BP_ARM
`endif
);

  localparam int RW = $clog2(RATE_DIV);
  localparam logic [RW-1:0] RATE_MAX = RW'(RATE_DIV - 1);
  localparam logic [15:0] BURST_INIT = 16'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BURST  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          state;
  logic [RW-1:0]   rate_cnt;
  logic [15:0]     remain;
  logic [15:0]     step_cnt;
  logic            ce;
  logic            busy;

  logic            wrap;
  logic            bp_hit;
  logic            bp_hold;

  assign wrap = (rate_cnt == RATE_MAX);

`ifdef STEP_CTRL_BREAKPOINT_EN
  assign bp_hit  = BP_ARM && (PC == BP_ADDR);
  assign bp_hold = BP_ARM;
`else
  assign bp_hit  = 1'b0;
  assign bp_hold = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      rate_cnt <= '0;
      remain   <= '0;
      step_cnt <= '0;
      ce       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ce <= 1'b0;
      if (HALT) begin
        // Any pending CE this cycle is dropped.
        state    <= S_HALTED;
        rate_cnt <= '0;
        remain   <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (RUN) begin
              state    <= S_RUN;
              rate_cnt <= '0;
              busy     <= 1'b1;
            end else if (BURST) begin
              state    <= S_BURST;
              rate_cnt <= '0;
              remain   <= BURST_INIT;
              busy     <= 1'b1;
            end else if (STEP && !ce) begin
              // Gating on ce keeps pulses from ever being back-to-back.
              ce       <= 1'b1;
              step_cnt <= step_cnt + 16'd1;
            end
          end
          S_RUN: begin
            if (!RUN) begin
              state    <= S_IDLE;
              rate_cnt <= '0;
              busy     <= 1'b0;
            end else if (wrap) begin
              rate_cnt <= '0;
              if (bp_hit) begin
                state <= S_HALTED;
                busy  <= 1'b0;
              end else begin
                ce       <= 1'b1;
                step_cnt <= step_cnt + 16'd1;
              end
            end else begin
              rate_cnt <= rate_cnt + 1'b1;
            end
          end
          S_BURST: begin
            if (wrap) begin
              rate_cnt <= '0;
              if (bp_hit) begin
                state  <= S_HALTED;
                remain <= '0;
                busy   <= 1'b0;
              end else begin
                ce       <= 1'b1;
                step_cnt <= step_cnt + 16'd1;
                remain   <= remain - 16'd1;
                // Leave together with the final pulse.
                if (remain == 16'd1) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end
            end else begin
              rate_cnt <= rate_cnt + 1'b1;
            end
          end
          S_HALTED: begin
            if (!RUN && !bp_hold) begin
              state <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign CPU_CE   = ce;
  assign BUSY     = busy;
  assign STEP_CNT = step_cnt;
  assign STATE    = state;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: scoreboard bench for step_ctrl (RATE_DIV=4, BURST_LEN=3).
// Expected CE cycles/counts are queued at stimulus time, popped on CPU_CE.

module tb_step_ctrl;

  logic        CLK;
  logic        RST;
  logic        STEP;
  logic        BURST;
  logic        RUN;
  logic        HALT;
  logic        CPU_CE;
  logic        BUSY;
  logic [15:0] STEP_CNT;
  logic [1:0]  STATE;
`ifdef STEP_CTRL_BREAKPOINT_EN
  logic [31:0] PC;
  logic [31:0] BP_ADDR;
  logic        BP_ARM;
`endif

  step_ctrl #(
    .RATE_DIV (4),
    .BURST_LEN(3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .STEP    (STEP),
    .BURST   (BURST),
    .RUN     (RUN),
    .HALT    (HALT),
    .CPU_CE  (CPU_CE),
    .BUSY    (BUSY),
    .STEP_CNT(STEP_CNT),
    .STATE   (STATE)
`ifdef STEP_CTRL_BREAKPOINT_EN
    ,
    .PC      (PC),
    .BP_ADDR (BP_ADDR),
    .BP_ARM  (BP_ARM)
`endif
  );

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0;
  logic [15:0] exp_cnt;
  logic        prev_ce = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ce(input int at);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.at  = at;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    STEP = 1'b0; BURST = 1'b0; RUN = 1'b0; HALT = 1'b0;
    @(negedge CLK);
    chk("rst_state", 32'(STATE), 0);
    chk("rst_cnt", 32'(STEP_CNT), 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_cnt = '0;
  endtask

  // Scoreboard consumer: every CE must be expected, at the right cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (CPU_CE) begin
      if (prev_ce) chk("ce_back2back", 32'(prev_ce), 0);
      if (sb.size() == 0) begin
        chk("ce_unexpected", 32'(CPU_CE), 0);
      end else begin
        e = sb.pop_front();
        chk("ce_cycle", cyc, e.at);
        chk("ce_count", 32'(STEP_CNT), 32'(e.cnt));
      end
`ifdef STEP_CTRL_BREAKPOINT_EN
      PC = PC + 32'd4;
`endif
    end
    prev_ce = CPU_CE;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    STEP = 1'b0; BURST = 1'b0; RUN = 1'b0; HALT = 1'b0;
    exp_cnt = '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
    PC = '0; BP_ADDR = 32'h8; BP_ARM = 1'b0;
`endif
    // Inputs are ignored while reset is held.
    repeat (2) @(negedge CLK);
    STEP = 1'b1; BURST = 1'b1; RUN = 1'b1;
    @(negedge CLK);
    chk("rst_state", 32'(STATE), 0);
    chk("rst_ce", 32'(CPU_CE), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_cnt", 32'(STEP_CNT), 0);
    STEP = 1'b0; BURST = 1'b0; RUN = 1'b0;
    RST = 1'b0;
    repeat (8) @(negedge CLK);

    // Single step.
    t0 = cyc;
    STEP = 1'b1;
    expect_ce(t0 + 1);
    @(negedge CLK);
    STEP = 1'b0;
    chk("step_state", 32'(STATE), 0);
    repeat (4) @(negedge CLK);
    chk("step_cnt", 32'(STEP_CNT), 1);

    // STEP held two cycles still yields one pulse.
    t0 = cyc;
    STEP = 1'b1;
    expect_ce(t0 + 1);
    repeat (2) @(negedge CLK);
    STEP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("step2_cnt", 32'(STEP_CNT), 2);

    // Free run for 20 cycles.
    do_reset();
    t0 = cyc;
    RUN = 1'b1;
    for (int k = 0; k < 4; k++) expect_ce(t0 + 5 + 4 * k);
    @(negedge CLK);
    chk("run_state", 32'(STATE), 1);
    chk("run_busy", 32'(BUSY), 1);
    repeat (19) @(negedge CLK);
    RUN = 1'b0;
    @(negedge CLK);
    chk("run_exit_state", 32'(STATE), 0);
    chk("run_exit_busy", 32'(BUSY), 0);
    repeat (8) @(negedge CLK);
    chk("run_cnt", 32'(STEP_CNT), 4);

    // Burst with STEP/BURST pulses ignored in flight.
    do_reset();
    t0 = cyc;
    BURST = 1'b1;
    for (int k = 0; k < 3; k++) expect_ce(t0 + 5 + 4 * k);
    @(negedge CLK);
    BURST = 1'b0;
    chk("burst_state", 32'(STATE), 2);
    chk("burst_busy", 32'(BUSY), 1);
    @(negedge CLK);
    STEP = 1'b1;
    @(negedge CLK);
    STEP = 1'b0;
    repeat (3) @(negedge CLK);
    BURST = 1'b1;
    @(negedge CLK);
    BURST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("burst_last_ce", 32'(CPU_CE), 1);
    chk("burst_end_state", 32'(STATE), 0);
    chk("burst_end_busy", 32'(BUSY), 0);
    repeat (6) @(negedge CLK);
    chk("burst_cnt", 32'(STEP_CNT), 3);

    // HALT in the cycle a RUN pulse is due.
    do_reset();
    t0 = cyc;
    RUN = 1'b1;
    repeat (4) @(negedge CLK);
    HALT = 1'b1;
    @(negedge CLK);
    chk("halt_state", 32'(STATE), 3);
    chk("halt_ce", 32'(CPU_CE), 0);
    chk("halt_busy", 32'(BUSY), 0);
    repeat (3) @(negedge CLK);
    HALT = 1'b0;
    repeat (3) @(negedge CLK);
    chk("halt_run_hold", 32'(STATE), 3);
    RUN = 1'b0;
    @(negedge CLK);
    chk("halt_exit", 32'(STATE), 0);

    // Priority: HALT beats everything.
    HALT = 1'b1; RUN = 1'b1; BURST = 1'b1; STEP = 1'b1;
    @(negedge CLK);
    BURST = 1'b0; STEP = 1'b0;
    chk("prio_halt", 32'(STATE), 3);
    HALT = 1'b0; RUN = 1'b0;
    @(negedge CLK);
    chk("prio_halt_exit", 32'(STATE), 0);

    // Priority: RUN beats BURST and STEP.
    t0 = cyc;
    RUN = 1'b1; BURST = 1'b1; STEP = 1'b1;
    expect_ce(t0 + 5);
    @(negedge CLK);
    BURST = 1'b0; STEP = 1'b0;
    chk("prio_run", 32'(STATE), 1);
    repeat (4) @(negedge CLK);
    RUN = 1'b0;
    @(negedge CLK);
    chk("prio_run_exit", 32'(STATE), 0);

    // Priority: BURST beats STEP.
    t0 = cyc;
    BURST = 1'b1; STEP = 1'b1;
    for (int k = 0; k < 3; k++) expect_ce(t0 + 5 + 4 * k);
    @(negedge CLK);
    BURST = 1'b0; STEP = 1'b0;
    chk("prio_burst", 32'(STATE), 2);
    repeat (12) @(negedge CLK);
    chk("prio_burst_end", 32'(STATE), 0);

    // Counter wrap from 0xFFFF.
    @(negedge CLK);
    force dut.step_cnt = 16'hFFFF;
    #1;
    release dut.step_cnt;
    exp_cnt = 16'hFFFF;
    @(negedge CLK);
    chk("preset_cnt", 32'(STEP_CNT), 32'hFFFF);
    t0 = cyc;
    STEP = 1'b1;
    expect_ce(t0 + 1);
    @(negedge CLK);
    STEP = 1'b0;
    chk("wrap_cnt", 32'(STEP_CNT), 0);

    // Reset mid-burst after one pulse.
    do_reset();
    t0 = cyc;
    BURST = 1'b1;
    expect_ce(t0 + 5);
    @(negedge CLK);
    BURST = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_state", 32'(STATE), 0);
    chk("mid_rst_ce", 32'(CPU_CE), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_cnt", 32'(STEP_CNT), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    exp_cnt = '0;
    repeat (12) @(negedge CLK);
    chk("post_rst_state", 32'(STATE), 0);

`ifdef STEP_CTRL_BREAKPOINT_EN
    // Breakpoint at PC 8 halts before the third pulse.
    do_reset();
    PC = '0;
    BP_ARM = 1'b1;
    t0 = cyc;
    RUN = 1'b1;
    expect_ce(t0 + 5);
    expect_ce(t0 + 9);
    repeat (13) @(negedge CLK);
    chk("bp_state", 32'(STATE), 3);
    chk("bp_ce", 32'(CPU_CE), 0);
    RUN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("bp_arm_hold", 32'(STATE), 3);
    BP_ARM = 1'b0;
    @(negedge CLK);
    chk("bp_exit", 32'(STATE), 0);
    chk("bp_cnt", 32'(STEP_CNT), 2);
`endif

    repeat (5) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
